clock_mode_ctrl: RTL and testbench

//  Mode controller and time keeper for the six-digit HH:MM:SS seven-segment clock.

---
 rtl/clock_mode_ctrl_pkg.sv | 34 +++
 rtl/clock_mode_ctrl_wrap_cnt.sv | 32 +++
 rtl/clock_mode_ctrl.sv | 171 +++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the HH:MM:SS clock mode controller.
//   mode_t          : 2-bit mode encoding, also driven on o_mode
//   SEC/MIN/HOUR_MAX: last legal value of each time field
//   SEC/MIN/HOUR_W  : bit width of each time field
//   next_mode()     : button-driven mode rotation RUN->SET_SEC->SET_MIN->SET_HOUR->RUN
package clock_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_RUN:      nxt = MODE_SET_SEC;
      MODE_SET_SEC:  nxt = MODE_SET_MIN;
      MODE_SET_MIN:  nxt = MODE_SET_HOUR;
      default:       nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_wrap_cnt.sv
// wrap_cnt: one time-field counter that rolls over to 0 after MAX.
//   clk    : system clock
//   rst    : asynchronous active-high reset, clears the count
//   i_inc  : advance the count by one on this edge
//   o_val  : current count, registered
//   o_wrap : high when i_inc will roll the count back to 0 (carry to the next field)
module wrap_cnt #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_val,
  output logic             o_wrap
);

  logic at_max;

  // ">=" rather than "==" so an out-of-range value returns to 0 on its next increment.
  assign at_max = (o_val >= WIDTH'(MAX));
  assign o_wrap = i_inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_val <= '0;
    end else if (i_inc) begin
      o_val <= at_max ? '0 : o_val + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: RUN/SET mode controller and time keeper for a six-digit HH:MM:SS display.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   i_tick  : 1 Hz single-cycle tick
//   i_mode  : debounced mode button pulse
//   i_inc   : debounced increment button pulse
//   o_sec   : seconds 0..59
//   o_min   : minutes 0..59
//   o_hour  : hours 0..23
//   o_mode  : current mode (see table)
//   o_blank : per-digit blank mask, [1:0] sec, [3:2] min, [5:4] hour
//
// state         | meaning
// MODE_RUN      | time advances on i_tick, i_inc ignored
// MODE_SET_SEC  | time frozen, i_inc bumps seconds, seconds digits blink
// MODE_SET_MIN  | time frozen, i_inc bumps minutes, minutes digits blink
// MODE_SET_HOUR | time frozen, i_inc bumps hours, hours digits blink
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int BLINK_DIV   = 25000000,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_mode,
  input  logic              i_inc,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [1:0]        o_mode,
  output logic [5:0]        o_blank
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TMO_W   = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC + 1) : 1;

  mode_t              mode_q, mode_d;
  logic               mode_chg;
  logic               timeout_hit;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [5:0]         blank_d;

  logic run_tick, edit;
  logic sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap;

  // ---------------- mode FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // A timeout tick that coincides with an i_inc does not fire: the press restarts the timer.
  assign timeout_hit = (mode_q != MODE_RUN) && i_tick && !i_inc &&
                       (tmo_cnt >= TMO_W'(TIMEOUT_SEC - 1));

  // ---------------- mode FSM: next state ----------------
  always_comb begin
    mode_d = mode_q;
    if (i_mode) begin
      mode_d = next_mode(mode_q);
    end else if (timeout_hit) begin
      mode_d = MODE_RUN;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  // ---------------- blink divider (next value) ----------------
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (mode_chg) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q >= BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // ---------------- mode FSM: outputs ----------------
  // The mask is built from next-state values so the registered o_blank lines up with o_mode.
  always_comb begin
    blank_d = '0;
    case (mode_d)
      MODE_SET_SEC:  blank_d[1:0] = {2{phase_d}};
      MODE_SET_MIN:  blank_d[3:2] = {2{phase_d}};
      MODE_SET_HOUR: blank_d[5:4] = {2{phase_d}};
      default:       blank_d      = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_blank <= '0;
    end else begin
      o_blank <= blank_d;
    end
  end

  assign o_mode = mode_q;

  // ---------------- timeout counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (i_mode || i_inc || mode_chg || (mode_q == MODE_RUN)) begin
      tmo_cnt <= '0;
    end else if (i_tick) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------- carry / increment steering ----------------
  // In SET modes a tick never reaches the counters; an edit loses to a same-edge mode press.
  assign run_tick = (mode_q == MODE_RUN) && i_tick;
  assign edit     = i_inc && !i_mode;

  assign sec_inc  = run_tick || (edit && (mode_q == MODE_SET_SEC));
  assign min_inc  = (run_tick && sec_wrap) || (edit && (mode_q == MODE_SET_MIN));
  assign hour_inc = (run_tick && sec_wrap && min_wrap) || (edit && (mode_q == MODE_SET_HOUR));

  wrap_cnt #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (sec_inc),
    .o_val  (o_sec),
    .o_wrap (sec_wrap)
  );

  wrap_cnt #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (min_inc),
    .o_val  (o_min),
    .o_wrap (min_wrap)
  );

  // Hour wrap has nothing to carry into; kept only to complete the counter interface.
  wrap_cnt #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (hour_inc),
    .o_val  (o_hour),
    .o_wrap (hour_wrap)
  );

  logic unused_ok;
  assign unused_ok = hour_wrap;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with BLINK_DIV=4 and TIMEOUT_SEC=3.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_inc = 1'b0;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic [5:0] o_blank;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.BLINK_DIV(4), .TIMEOUT_SEC(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (i_tick),
    .i_mode  (i_mode),
    .i_inc   (i_inc),
    .o_sec   (o_sec),
    .o_min   (o_min),
    .o_hour  (o_hour),
    .o_mode  (o_mode),
    .o_blank (o_blank)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Time compared as decimal hhmmss so the report is readable.
  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk(tag, int'(o_hour) * 10000 + int'(o_min) * 100 + int'(o_sec), h * 10000 + m * 100 + s);
  endtask

  // Called at a negedge; holds the pulses across exactly one posedge and returns at the next negedge.
  task automatic step(input logic t, input logic m, input logic i);
    i_tick = t;
    i_mode = m;
    i_inc  = i;
    @(negedge clk);
    i_tick = 1'b0;
    i_mode = 1'b0;
    i_inc  = 1'b0;
  endtask

  task automatic steps(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  initial begin
    // ---- reset ----
    repeat (2) @(negedge clk);
    chk_time("reset_time", 0, 0, 0);
    chk("reset_mode", o_mode, 0);
    chk("reset_blank", o_blank, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- 1: 61 ticks in RUN ----
    steps(61, 1'b1, 1'b0, 1'b0);
    chk_time("run_61_ticks", 0, 1, 1);
    chk("run_mode", o_mode, 0);
    chk("run_blank", o_blank, 0);
    step(1'b0, 1'b0, 1'b1);
    chk_time("run_inc_ignored", 0, 1, 1);

    // ---- 2: preload 23:59:59 through the SET modes, then one tick ----
    step(1'b0, 1'b1, 1'b0);
    steps(58, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(58, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(23, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk_time("preload", 23, 59, 59);
    chk("preload_mode", o_mode, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_time("midnight_rollover", 0, 0, 0);

    // ---- 3: SET_SEC edit from 00:00:58, wrap without carry ----
    steps(58, 1'b1, 1'b0, 1'b0);
    chk_time("run_to_58", 0, 0, 58);
    step(1'b0, 1'b1, 1'b0);
    chk("enter_set_sec", o_mode, 1);
    chk("set_sec_blank_first", o_blank, 0);
    step(1'b0, 1'b0, 1'b1);
    chk_time("set_sec_inc1", 0, 0, 59);
    step(1'b1, 1'b0, 1'b0);
    chk_time("set_sec_tick_frozen", 0, 0, 59);
    step(1'b0, 1'b0, 1'b1);
    chk_time("set_sec_wrap_no_carry", 0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_time("set_sec_inc3", 0, 0, 1);
    chk("set_sec_still", o_mode, 1);

    // ---- 4: SET_MIN, mode+inc same edge, then blink pattern in SET_HOUR ----
    step(1'b0, 1'b1, 1'b0);
    chk("enter_set_min", o_mode, 2);
    step(1'b0, 1'b0, 1'b1);
    chk_time("set_min_inc", 0, 1, 1);
    step(1'b0, 1'b1, 1'b1);
    chk("mode_beats_inc_mode", o_mode, 3);
    chk_time("mode_beats_inc_time", 0, 1, 1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("blink_%0d", k), o_blank, ((k / 4) % 2 == 1) ? 6'b110000 : 6'b000000);
      @(negedge clk);
    end

    // ---- 5: timeout after 3 ticks in SET_HOUR ----
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("timeout_not_yet", o_mode, 3);
    step(1'b1, 1'b0, 1'b0);
    chk("timeout_mode", o_mode, 0);
    chk_time("timeout_time_kept", 0, 1, 1);
    chk("timeout_blank", o_blank, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_time("after_timeout_tick", 0, 1, 2);
    step(1'b1, 1'b1, 1'b0);
    chk_time("run_tick_with_mode_time", 0, 1, 3);
    chk("run_tick_with_mode_mode", o_mode, 1);

    // ---- 6: async reset mid-edit ----
    step(1'b0, 1'b1, 1'b0);
    steps(41, 1'b0, 1'b0, 1'b1);
    chk_time("set_min_42", 0, 42, 3);
    chk("set_min_mode", o_mode, 2);
    #2 rst = 1'b1;
    #1;
    chk_time("async_rst_time", 0, 0, 0);
    chk("async_rst_mode", o_mode, 0);
    chk("async_rst_blank", o_blank, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk_time("post_rst_tick", 0, 0, 1);
    chk("post_rst_mode", o_mode, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
